writeback_arbiter: RTL

//  Writeback stage: collects completed results from the four functional units and

---
 rtl/writeback_arbiter_if.sv | 40 ++++
 rtl/writeback_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/writeback_arbiter_if.sv
// Writeback bus: unit result handshakes in, register/predicate write port and
// scoreboard release strobes out.
interface writeback_arbiter_if #(
  parameter int REG_BITS      = 4,
  parameter int PRED_REG_BITS = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_UNITS     = 4
);
  logic [NUM_UNITS-1:0]               unit_valid;
  logic [NUM_UNITS-1:0]               unit_ready;
  logic [NUM_UNITS-1:0]               unit_reg_valid;
  logic [NUM_UNITS*REG_BITS-1:0]      unit_reg_addr;
  logic [NUM_UNITS*DATA_WIDTH-1:0]    unit_reg_data;
  logic [NUM_UNITS-1:0]               unit_pred_valid;
  logic [NUM_UNITS*PRED_REG_BITS-1:0] unit_pred_addr;
  logic [NUM_UNITS-1:0]               unit_pred_data;
  logic                               wr_reg;
  logic [REG_BITS-1:0]                wr_reg_addr;
  logic [DATA_WIDTH-1:0]              wr_reg_data;
  logic                               wr_pred;
  logic [PRED_REG_BITS-1:0]           wr_pred_addr;
  logic                               wr_pred_data;
  logic                               free_complex_alu;
  logic                               free_fpu;
  logic                               free_mem_unit;

  modport master (
    output unit_valid, unit_reg_valid, unit_reg_addr, unit_reg_data,
           unit_pred_valid, unit_pred_addr, unit_pred_data,
    input  unit_ready, wr_reg, wr_reg_addr, wr_reg_data, wr_pred, wr_pred_addr,
           wr_pred_data, free_complex_alu, free_fpu, free_mem_unit
  );

  modport slave (
    input  unit_valid, unit_reg_valid, unit_reg_addr, unit_reg_data,
           unit_pred_valid, unit_pred_addr, unit_pred_data,
    output unit_ready, wr_reg, wr_reg_addr, wr_reg_data, wr_pred, wr_pred_addr,
           wr_pred_data, free_complex_alu, free_fpu, free_mem_unit
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: one holding buffer per functional unit, round-robin grant,
// registered single-cycle write and release strobes.
module writeback_arbiter #(
  parameter int REG_BITS      = 4,
  parameter int PRED_REG_BITS = 2,
  parameter int DATA_WIDTH    = 32
) (
  input logic             clk,
  input logic             reset,
  writeback_arbiter_if.slave bus
);
  localparam int NUM_UNITS = 4;

  logic [NUM_UNITS-1:0]     buf_valid_q;
  logic [NUM_UNITS-1:0]     buf_reg_valid_q;
  logic [REG_BITS-1:0]      buf_reg_addr_q  [NUM_UNITS];
  logic [DATA_WIDTH-1:0]    buf_reg_data_q  [NUM_UNITS];
  logic [NUM_UNITS-1:0]     buf_pred_valid_q;
  logic [PRED_REG_BITS-1:0] buf_pred_addr_q [NUM_UNITS];
  logic [NUM_UNITS-1:0]     buf_pred_data_q;

  logic [1:0]               ptr_q, ptr_d;
  logic                     wr_reg_q, wr_reg_d;
  logic [REG_BITS-1:0]      wr_reg_addr_q, wr_reg_addr_d;
  logic [DATA_WIDTH-1:0]    wr_reg_data_q, wr_reg_data_d;
  logic                     wr_pred_q, wr_pred_d;
  logic [PRED_REG_BITS-1:0] wr_pred_addr_q, wr_pred_addr_d;
  logic                     wr_pred_data_q, wr_pred_data_d;
  logic [2:0]               free_q, free_d;

  logic [NUM_UNITS-1:0]     grant;
  logic                     grant_any;
  logic [1:0]               grant_idx;
  logic [1:0]               scan_idx;
  logic                     hit;
  logic [NUM_UNITS-1:0]     unit_ready;

  // Round-robin pick: first occupied buffer at or after the pointer, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    scan_idx  = 2'd0;
    hit       = 1'b0;
    for (int off = 0; off < NUM_UNITS; off++) begin
      scan_idx  = ptr_q + 2'(off);
      hit       = ~grant_any & buf_valid_q[scan_idx];
      grant_idx = hit ? scan_idx : grant_idx;
      grant_any = grant_any | hit;
    end
    grant = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
  end

  assign unit_ready     = ~buf_valid_q | grant;
  assign bus.unit_ready = unit_ready;

  // Next-state for the write port, release strobes and pointer.
  always_comb begin
    wr_reg_d       = grant_any & buf_reg_valid_q[grant_idx];
    wr_pred_d      = grant_any & buf_pred_valid_q[grant_idx];
    wr_reg_addr_d  = grant_any ? buf_reg_addr_q[grant_idx]  : wr_reg_addr_q;
    wr_reg_data_d  = grant_any ? buf_reg_data_q[grant_idx]  : wr_reg_data_q;
    wr_pred_addr_d = grant_any ? buf_pred_addr_q[grant_idx] : wr_pred_addr_q;
    wr_pred_data_d = grant_any ? buf_pred_data_q[grant_idx] : wr_pred_data_q;
    free_d         = {grant_any & (grant_idx == 2'd3),
                      grant_any & (grant_idx == 2'd2),
                      grant_any & (grant_idx == 2'd1)};
    ptr_d          = grant_any ? (grant_idx + 2'd1) : ptr_q;
  end

  // Output and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q          <= 2'd0;
      wr_reg_q       <= 1'b0;
      wr_reg_addr_q  <= '0;
      wr_reg_data_q  <= '0;
      wr_pred_q      <= 1'b0;
      wr_pred_addr_q <= '0;
      wr_pred_data_q <= 1'b0;
      free_q         <= 3'b000;
    end else begin
      ptr_q          <= ptr_d;
      wr_reg_q       <= wr_reg_d;
      wr_reg_addr_q  <= wr_reg_addr_d;
      wr_reg_data_q  <= wr_reg_data_d;
      wr_pred_q      <= wr_pred_d;
      wr_pred_addr_q <= wr_pred_addr_d;
      wr_pred_data_q <= wr_pred_data_d;
      free_q         <= free_d;
    end
  end

  // Holding buffers: a capture wins over a drain so a granted slot refills without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q      <= '0;
      buf_reg_valid_q  <= '0;
      buf_pred_valid_q <= '0;
      buf_pred_data_q  <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        buf_reg_addr_q[i]  <= '0;
        buf_reg_data_q[i]  <= '0;
        buf_pred_addr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (bus.unit_valid[i] && unit_ready[i]) begin
          buf_valid_q[i]      <= 1'b1;
          buf_reg_valid_q[i]  <= bus.unit_reg_valid[i];
          buf_reg_addr_q[i]   <= bus.unit_reg_addr[i*REG_BITS +: REG_BITS];
          buf_reg_data_q[i]   <= bus.unit_reg_data[i*DATA_WIDTH +: DATA_WIDTH];
          buf_pred_valid_q[i] <= bus.unit_pred_valid[i];
          buf_pred_addr_q[i]  <= bus.unit_pred_addr[i*PRED_REG_BITS +: PRED_REG_BITS];
          buf_pred_data_q[i]  <= bus.unit_pred_data[i];
        end else if (grant[i]) begin
          buf_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.wr_reg           = wr_reg_q;
  assign bus.wr_reg_addr      = wr_reg_addr_q;
  assign bus.wr_reg_data      = wr_reg_data_q;
  assign bus.wr_pred          = wr_pred_q;
  assign bus.wr_pred_addr     = wr_pred_addr_q;
  assign bus.wr_pred_data     = wr_pred_data_q;
  assign bus.free_complex_alu = free_q[0];
  assign bus.free_fpu         = free_q[1];
  assign bus.free_mem_unit    = free_q[2];
endmodule
